button_event_queue: RTL and testbench



---
 rtl/btn_io_pkg.sv | 35 +++
 rtl/btn_debounce.sv | 112 +++++++++++
 rtl/button_event_queue.sv | 129 ++++++++++++
 tb/tb_button_event_queue.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_io_pkg.sv
// Shared constants for the push-button event port: button indices,
// event-word field positions, MMIO addresses and the drain priority picker.
package btn_io_pkg;

    localparam int NUM_BTN = 4;

    // Button bit positions inside btn_raw and inside an event entry
    localparam int BTN_U = 3;
    localparam int BTN_L = 2;
    localparam int BTN_D = 1;
    localparam int BTN_R = 0;

    // Field positions inside the q_io event word
    localparam int VALID_BIT = 8;
    localparam int CNT_LSB   = 9;
    localparam int CNT_W     = 4;
    localparam int OVF_BIT   = 15;

    // dmem word addresses of the MMIO ports that share the q_dmem mux
    localparam logic [31:0] IO_SW  = 32'd4096;
    localparam logic [31:0] IO_LED = 32'd4097;
    localparam logic [31:0] IO_BTN = 32'd4098;

    // One-hot pick of the highest-priority request, order U > L > D > R
    function automatic logic [3:0] pick_highest(input logic [3:0] req);
        logic [3:0] sel;
        sel = '0;
        if (req[BTN_U])      sel[BTN_U] = 1'b1;
        else if (req[BTN_L]) sel[BTN_L] = 1'b1;
        else if (req[BTN_D]) sel[BTN_D] = 1'b1;
        else if (req[BTN_R]) sel[BTN_R] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchroniser, hold-time debounce and a one-cycle
// rise pulse when the accepted level goes 0->1.
// Optional build macro: AUTOREPEAT_EN adds a hold-to-repeat pulse generator.
module btn_debounce
    import btn_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 400000
`ifdef AUTOREPEAT_EN
    , parameter int REPEAT_DELAY  = 20000000
    , parameter int REPEAT_PERIOD = 6000000
`endif
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o
);

    localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

    logic        sync0_q, sync1_q;
    logic        stable_q, stable_d;
    logic [19:0] cnt_q, cnt_d;
    logic        rise_q, rise_d;

    // Two-stage synchroniser for the asynchronous button level
    always_ff @(posedge clock) begin
        if (reset) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
        end else begin
            sync0_q <= raw_i;
            sync1_q <= sync0_q;
        end
    end

    // Accept a new level only after it has differed from the stable one for
    // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync1_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            stable_d = sync1_q;
        end else begin
            cnt_d = cnt_q + 20'd1;
        end
    end

`ifdef AUTOREPEAT_EN
    logic [31:0] rep_cnt_q, rep_cnt_d;
    logic        rep_first_q, rep_first_d;
    logic        rep_fire;

    // While held, fire once after REPEAT_DELAY and then every REPEAT_PERIOD
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        rep_fire    = 1'b0;
        if (!stable_q) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b0;
        end else if (!rep_first_q && rep_cnt_q == 32'(REPEAT_DELAY - 1)) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
            rep_fire    = 1'b1;
        end else if (rep_first_q && rep_cnt_q == 32'(REPEAT_PERIOD - 1)) begin
            rep_cnt_d = '0;
            rep_fire  = 1'b1;
        end else begin
            rep_cnt_d = rep_cnt_q + 32'd1;
        end
        rise_d = (stable_d & ~stable_q) | rep_fire;
    end

    // Repeat counter state
    always_ff @(posedge clock) begin
        if (reset) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`else
    // Press pulse: accepted level goes 0->1 (releases produce nothing)
    always_comb begin
        rise_d = stable_d & ~stable_q;
    end
`endif

    // Debounce counter, accepted level and registered rise pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;

endmodule

// File: rtl/button_event_queue.sv
// Push-button MMIO port: four debounced buttons feed per-button pending bits,
// drained one per cycle (U > L > D > R) into a small event FIFO that the
// processor pops by loading from IO_ADDR.
// Optional build macro: AUTOREPEAT_EN (hold-to-repeat press events).
module button_event_queue
    import btn_io_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 400000,
    parameter int          FIFO_DEPTH      = 4,
    parameter logic [31:0] IO_ADDR         = IO_BTN
`ifdef AUTOREPEAT_EN
    , parameter int        REPEAT_DELAY    = 20000000
    , parameter int        REPEAT_PERIOD   = 6000000
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  btn_raw,
    input  logic [31:0] mem_addr,
    input  logic        wren,
    output logic        io_hit,
    output logic [31:0] q_io,
    output logic        irq_pending
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [3:0] btn_stable;
    logic [3:0] btn_rise;
    logic [3:0] press;

    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          io_hit_q;
    logic          irq_q, irq_d;
    logic [3:0]    pending_q, pending_d;

    logic       fifo_empty, fifo_full;
    logic       pop_edge, pop, push, drop;
    logic [3:0] push_sel;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef AUTOREPEAT_EN
            , .REPEAT_DELAY(REPEAT_DELAY)
            , .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
        ) u_debounce (
            .clock    (clock),
            .reset    (reset),
            .raw_i    (btn_raw[g]),
            .stable_o (btn_stable[g]),
            .rise_o   (btn_rise[g])
        );
    end

    // Read handshake: the load "offers" when io_hit is high; the head word is
    // presented combinationally on q_io and is consumed (popped) exactly once,
    // at the clock edge ending the first io_hit cycle, however long the
    // processor stalls with io_hit held high. An empty FIFO offers valid=0 and
    // the pop is ignored.
    always_comb begin
        io_hit     = (mem_addr == IO_ADDR) && !wren;
        pop_edge   = io_hit && !io_hit_q;
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CW'(FIFO_DEPTH));
        pop        = pop_edge && !fifo_empty;
        // A rise only counts while the accepted level is high
        press      = btn_rise & btn_stable;
        push_sel   = pick_highest(pending_q);
        push       = (|pending_q) && (!fifo_full || pop);
        drop       = (|pending_q) && fifo_full && !pop;
        pending_d  = (pending_q & ~push_sel) | press;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (drop)          ovf_d = 1'b1;
        else if (pop_edge) ovf_d = 1'b0;
        irq_d = (count_d != '0);
    end

    // Event word: head entry, valid, pre-pop count and sticky overflow
    always_comb begin
        q_io = '0;
        if (!fifo_empty) q_io[3:0] = mem_q[rd_ptr_q];
        q_io[VALID_BIT]            = !fifo_empty;
        q_io[CNT_LSB +: CNT_W]     = CNT_W'(count_q);
        q_io[OVF_BIT]              = ovf_q;
    end

    // FIFO control state, pending bits and registered interrupt
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            io_hit_q  <= 1'b0;
            irq_q     <= 1'b0;
            pending_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            io_hit_q  <= io_hit;
            irq_q     <= irq_d;
            pending_q <= pending_d;
        end
    end

    // Event storage; contents are masked by count so they need no reset
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= push_sel;
    end

    assign irq_pending = irq_q;

endmodule

// File: tb/tb_button_event_queue.sv
// Self-checking bench for button_event_queue (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4).
// A reference model tracks each button as a window of recent samples, a set
// of pending presses and a bounded event queue.
module tb_button_event_queue;

    localparam int          D      = 4;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] IO     = 32'd4098;
    localparam logic [31:0] IO_LED = 32'd4097;

    logic        clock;
    logic        reset;
    logic [3:0]  btn_raw;
    logic [31:0] mem_addr;
    logic        wren;
    logic        io_hit;
    logic [31:0] q_io;
    logic        irq_pending;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [D+1:0] m_hist [4];
    logic [3:0]   m_stable;
    logic [3:0]   m_pend;
    logic         m_ovf;
    logic [3:0]   exp_q[$];

    button_event_queue #(
        .DEBOUNCE_CYCLES(D),
        .FIFO_DEPTH(DEPTH),
        .IO_ADDR(IO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .mem_addr    (mem_addr),
        .wren        (wren),
        .io_hit      (io_hit),
        .q_io        (q_io),
        .irq_pending (irq_pending)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    // A level is accepted once the button has shown the opposite level for D
    // consecutive samples (seen through a 2-sample synchroniser delay).
    task automatic model_step();
        int         hi;
        logic [3:0] oh;
        if (reset) begin
            for (int b = 0; b < 4; b++) m_hist[b] = '0;
            m_stable = '0;
            m_pend   = '0;
            m_ovf    = 1'b0;
            exp_q.delete();
        end else begin
            hi = -1;
            for (int b = 0; b < 4; b++) if (m_pend[b]) hi = b;
            if (hi >= 0) begin
                oh     = '0;
                oh[hi] = 1'b1;
                if (exp_q.size() < DEPTH) exp_q.push_back(oh);
                else m_ovf = 1'b1;
                m_pend[hi] = 1'b0;
            end
            for (int b = 0; b < 4; b++) begin
                m_hist[b] = {m_hist[b][D:0], btn_raw[b]};
                if (m_hist[b][D+1:2] == {D{~m_stable[b]}}) begin
                    m_stable[b] = ~m_stable[b];
                    if (m_stable[b]) m_pend[b] = 1'b1;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    function automatic logic [31:0] model_word();
        logic [31:0] w;
        w = '0;
        if (exp_q.size() != 0) begin
            w[3:0] = exp_q[0];
            w[8]   = 1'b1;
        end
        w[12:9] = 4'(exp_q.size());
        w[15]   = m_ovf;
        return w;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int cycles);
        @(negedge clock);
        reset = 1'b1;
        repeat (cycles) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clock);
    endtask

    // One load from the event port; the model pops once for the read edge
    task automatic do_read(output logic [31:0] got, output logic hit);
        @(negedge clock);
        mem_addr = IO;
        wren     = 1'b0;
        #1;
        got = q_io;
        hit = io_hit;
        @(negedge clock);
        mem_addr = 32'd0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        m_ovf = 1'b0;
    endtask

    task automatic press_release(input int b);
        @(negedge clock);
        btn_raw[b] = 1'b1;
        idle(D + 4);
        btn_raw[b] = 1'b0;
        idle(D + 4);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset(3);
        #1;
        checks++;
        if (q_io !== 32'h0) begin
            failures++;
            $display("FAIL reset_q_io: got %h expected %h", q_io, 32'h0);
        end
        checks++;
        if (irq_pending !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq: got %b expected 0", irq_pending);
        end
        checks++;
        if (io_hit !== 1'b0) begin
            failures++;
            $display("FAIL reset_io_hit: got %b expected 0", io_hit);
        end
    endtask

    task automatic test_single_press();
        logic [31:0] got, exp;
        logic        hit;
        do_reset(2);
        @(negedge clock);
        btn_raw = 4'b1000;
        idle(10);
        exp = model_word();
        do_read(got, hit);
        checks++;
        if (got !== 32'h00000308 || got !== exp) begin
            failures++;
            $display("FAIL single_read1: got %h expected %h (model %h)", got, 32'h308, exp);
        end
        checks++;
        if (hit !== 1'b1) begin
            failures++;
            $display("FAIL single_io_hit: got %b expected 1", hit);
        end
        btn_raw = 4'b0000;
        do_read(got, hit);
        checks++;
        if (got !== 32'h0) begin
            failures++;
            $display("FAIL single_read2: got %h expected %h", got, 32'h0);
        end
    endtask

    task automatic test_bounce();
        do_reset(2);
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (c % 2 == 0) btn_raw[0] = ~btn_raw[0];
            #1;
            checks++;
            if (q_io[8] !== 1'b0) begin
                failures++;
                $display("FAIL bounce_valid: cycle %0d got %b expected 0", c, q_io[8]);
            end
        end
        btn_raw = 4'b0000;
        idle(D + 6);
        checks++;
        if (q_io !== 32'h0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bounce_final: got %h expected %h", q_io, 32'h0);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] got;
        logic        hit;
        logic [31:0] want [4];
        want[0] = 32'h908; want[1] = 32'h704; want[2] = 32'h502; want[3] = 32'h301;
        do_reset(2);
        @(negedge clock);
        btn_raw = 4'b1111;
        idle(D + 6);
        btn_raw = 4'b0000;
        idle(D + 6);
        for (int k = 0; k < 4; k++) begin
            do_read(got, hit);
            checks++;
            if (got !== want[k]) begin
                failures++;
                $display("FAIL simul_read%0d: got %h expected %h", k, got, want[k]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] got, exp;
        logic        hit;
        do_reset(2);
        press_release(3);
        press_release(2);
        press_release(1);
        press_release(0);
        press_release(3);
        #1;
        checks++;
        if (q_io !== 32'h00008908 || q_io !== model_word()) begin
            failures++;
            $display("FAIL ovf_word: got %h expected %h", q_io, 32'h8908);
        end
        checks++;
        if (irq_pending !== 1'b1) begin
            failures++;
            $display("FAIL ovf_irq: got %b expected 1", irq_pending);
        end
        do_read(got, hit);
        checks++;
        if (got !== 32'h8908) begin
            failures++;
            $display("FAIL ovf_read1: got %h expected %h", got, 32'h8908);
        end
        exp = model_word();
        do_read(got, hit);
        checks++;
        if (got !== 32'h704 || got !== exp) begin
            failures++;
            $display("FAIL ovf_read2: got %h expected %h", got, 32'h704);
        end
    endtask

    task automatic test_stall_pop();
        logic [31:0] obs [3];
        do_reset(2);
        @(negedge clock);
        btn_raw = 4'b1100;
        idle(D + 6);
        btn_raw = 4'b0000;
        idle(D + 6);
        // write and foreign-address accesses must not hit or pop
        mem_addr = IO;
        wren     = 1'b1;
        #1;
        checks++;
        if (io_hit !== 1'b0) begin
            failures++;
            $display("FAIL wren_io_hit: got %b expected 0", io_hit);
        end
        @(negedge clock);
        mem_addr = IO_LED;
        wren     = 1'b0;
        #1;
        checks++;
        if (io_hit !== 1'b0) begin
            failures++;
            $display("FAIL led_io_hit: got %b expected 0", io_hit);
        end
        @(negedge clock);
        mem_addr = IO;
        for (int c = 0; c < 3; c++) begin
            #1;
            obs[c] = q_io;
            @(negedge clock);
        end
        mem_addr = 32'd0;
        void'(exp_q.pop_front());
        m_ovf = 1'b0;
        #1;
        checks++;
        if (obs[0] !== 32'h508) begin
            failures++;
            $display("FAIL stall_first: got %h expected %h", obs[0], 32'h508);
        end
        checks++;
        if (obs[1] !== 32'h304 || obs[2] !== 32'h304) begin
            failures++;
            $display("FAIL stall_hold: got %h %h expected %h", obs[1], obs[2], 32'h304);
        end
        checks++;
        if (q_io !== 32'h304 || q_io !== model_word()) begin
            failures++;
            $display("FAIL stall_after: got %h expected %h", q_io, 32'h304);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got, exp;
        logic        hit;
        do_reset(2);
        @(negedge clock);
        btn_raw = 4'b1110;
        idle(D + 6);
        btn_raw = 4'b0000;
        idle(D + 6);
        checks++;
        if (q_io !== 32'h708) begin
            failures++;
            $display("FAIL mid_queued: got %h expected %h", q_io, 32'h708);
        end
        btn_raw = 4'b0001;
        idle(3);
        do_reset(1);
        #1;
        checks++;
        if (q_io !== 32'h0 || irq_pending !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: got q_io=%h irq=%b expected 0 0", q_io, irq_pending);
        end
        idle(D + 8);
        exp = model_word();
        do_read(got, hit);
        checks++;
        if (got !== 32'h301 || got !== exp) begin
            failures++;
            $display("FAIL mid_event: got %h expected %h", got, 32'h301);
        end
        btn_raw = 4'b0000;
        idle(D + 4);
        do_read(got, hit);
        checks++;
        if (got !== 32'h0) begin
            failures++;
            $display("FAIL mid_single: got %h expected %h", got, 32'h0);
        end
    endtask

    task automatic test_random();
        int          hold [4];
        logic [31:0] got, exp;
        logic        hit;
        do_reset(2);
        for (int r = 0; r < 4; r++) begin
            for (int b = 0; b < 4; b++) hold[b] = 0;
            for (int c = 0; c < 150; c++) begin
                @(negedge clock);
                for (int b = 0; b < 4; b++) begin
                    if (hold[b] == 0) begin
                        if ($urandom_range(0, 1) == 1) btn_raw[b] = ~btn_raw[b];
                        hold[b] = $urandom_range(1, 2 * D);
                    end else begin
                        hold[b] = hold[b] - 1;
                    end
                end
            end
            @(negedge clock);
            btn_raw = 4'b0000;
            idle(D + 10);
            #1;
            checks++;
            if (irq_pending !== (exp_q.size() != 0)) begin
                failures++;
                $display("FAIL rand_irq: round %0d got %b expected %b", r, irq_pending, exp_q.size() != 0);
            end
            for (int k = 0; k < DEPTH + 1; k++) begin
                exp = model_word();
                do_read(got, hit);
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL rand_read: round %0d read %0d got %h expected %h", r, k, got, exp);
                end
            end
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        reset    = 1'b1;
        btn_raw  = 4'b0000;
        mem_addr = 32'd0;
        wren     = 1'b0;
        test_reset();
        test_single_press();
        test_bounce();
        test_simultaneous();
        test_overflow();
        test_stall_pop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
